pong_physics: RTL and testbench

Game-state engine for the Pong display path. It sits directly upstream of the `graphics` renderer and owns all per-frame motion. It advances ball and paddle positions once per `tick` strobe, handles wall and paddle bounces, scoring, serve delay and game over. It drives the renderer's ball and paddle coordinate inputs from registers.

---
 rtl/pong_physics_if.sv | 34 +++
 rtl/pong_physics.sv | 166 ++++++++++++++++
 tb/tb_pong_physics.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_physics_if.sv
// Pong engine port bundle: tick/button inputs and the
// registered coordinates, scores and state for the renderer.
interface pong_physics_if;
  logic       tick;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle_one_x;
  logic [9:0] paddle_one_y;
  logic [9:0] paddle_two_x;
  logic [9:0] paddle_two_y;
  logic [3:0] score_one;
  logic [3:0] score_two;
  logic [1:0] state;

  modport master (
    output tick, p1_up, p1_down, p2_up, p2_down,
    input  ball_x, ball_y,
    input  paddle_one_x, paddle_one_y,
    input  paddle_two_x, paddle_two_y,
    input  score_one, score_two, state
  );

  modport slave (
    input  tick, p1_up, p1_down, p2_up, p2_down,
    output ball_x, ball_y,
    output paddle_one_x, paddle_one_y,
    output paddle_two_x, paddle_two_y,
    output score_one, score_two, state
  );
endinterface

// File: rtl/pong_physics.sv
// Pong game-state engine: ball/paddle motion, bounces,
// scoring, serve delay and game over, advanced once per tick.
module pong_physics #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_TICKS  = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic          clk50M,
  input  logic          rst,
  pong_physics_if.slave bus
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [9:0] CX   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] CY   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] PY0  = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] PMAX = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] P1X  = 10'(16);
  localparam logic [9:0] P2X  = 10'(SCREEN_W - 16 - PADDLE_W);
  localparam logic [9:0] HIT1 = 10'(16 + PADDLE_W);
  localparam logic [9:0] HIT2 = 10'(SCREEN_W - 16 - PADDLE_W - BALL_SIZE);
  localparam logic [9:0] XMAX = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0] YMAX = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] SPD  = 10'(PADDLE_SPEED);
  localparam logic [9:0] BS   = 10'(BALL_SIZE);
  localparam logic [9:0] PH   = 10'(PADDLE_H);
  localparam logic [3:0] WIN  = 4'(WIN_SCORE);
  localparam logic [7:0] SLST = 8'(SERVE_TICKS - 1);

  state_t     state_q, state_n;
  logic [9:0] bx_q, bx_n, by_q, by_n;
  logic [9:0] p1_q, p1_n, p2_q, p2_n;
  logic [3:0] s1_q, s1_n, s2_q, s2_n;
  logic [7:0] cnt_q, cnt_n;
  logic       dx_q, dx_n, dy_q, dy_n;
  logic [9:0] nx, ny;
  logic [3:0] s1_inc, s2_inc;

  // clamp compares happen before the add/sub so y never wraps
  function automatic logic [9:0] pad_next(
    input logic [9:0] y,
    input logic       up,
    input logic       dn
  );
    logic [9:0] r;
    r = y;
    if (up && !dn)
      r = (y < SPD) ? 10'd0 : y - SPD;
    else if (dn && !up)
      r = (y > PMAX - SPD) ? PMAX : y + SPD;
    return r;
  endfunction

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state_q <= SERVE;
      bx_q    <= CX;
      by_q    <= CY;
      p1_q    <= PY0;
      p2_q    <= PY0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      cnt_q   <= 8'd0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      bx_q    <= bx_n;
      by_q    <= by_n;
      p1_q    <= p1_n;
      p2_q    <= p2_n;
      s1_q    <= s1_n;
      s2_q    <= s2_n;
      cnt_q   <= cnt_n;
      dx_q    <= dx_n;
      dy_q    <= dy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    bx_n    = bx_q;
    by_n    = by_q;
    p1_n    = p1_q;
    p2_n    = p2_q;
    s1_n    = s1_q;
    s2_n    = s2_q;
    cnt_n   = cnt_q;
    dx_n    = dx_q;
    dy_n    = dy_q;
    nx      = dx_q ? bx_q + 10'd1 : bx_q - 10'd1;
    ny      = dy_q ? by_q + 10'd1 : by_q - 10'd1;
    s1_inc  = s1_q + 4'd1;
    s2_inc  = s2_q + 4'd1;
    if (bus.tick) begin
      p1_n = pad_next(p1_q, bus.p1_up, bus.p1_down);
      p2_n = pad_next(p2_q, bus.p2_up, bus.p2_down);
      unique case (state_q)
        SERVE: begin
          if (cnt_q == SLST) begin
            state_n = PLAY;
            cnt_n   = 8'd0;
          end else begin
            cnt_n   = cnt_q + 8'd1;
          end
        end
        PLAY: begin
          bx_n = nx;
          by_n = ny;
          if (ny == 10'd0)
            dy_n = 1'b1;
          else if (ny == YMAX)
            dy_n = 1'b0;
          // overlap uses pre-update paddle positions
          if (!dx_q && nx == HIT1 &&
              ny + BS > p1_q && ny < p1_q + PH)
            dx_n = 1'b1;
          if (dx_q && nx == HIT2 &&
              ny + BS > p2_q && ny < p2_q + PH)
            dx_n = 1'b0;
          if (nx == 10'd0) begin
            s2_n    = s2_inc;
            bx_n    = CX;
            by_n    = CY;
            cnt_n   = 8'd0;
            dx_n    = 1'b0;
            state_n = (s2_inc == WIN) ? OVER : SERVE;
          end else if (nx == XMAX) begin
            s1_n    = s1_inc;
            bx_n    = CX;
            by_n    = CY;
            cnt_n   = 8'd0;
            dx_n    = 1'b1;
            state_n = (s1_inc == WIN) ? OVER : SERVE;
          end
        end
        OVER: begin
          bx_n = CX;
          by_n = CY;
        end
        default: state_n = SERVE;
      endcase
    end
  end

  assign bus.ball_x       = bx_q;
  assign bus.ball_y       = by_q;
  assign bus.paddle_one_x = P1X;
  assign bus.paddle_one_y = p1_q;
  assign bus.paddle_two_x = P2X;
  assign bus.paddle_two_y = p2_q;
  assign bus.score_one    = s1_q;
  assign bus.score_two    = s2_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pong_physics.sv
// Bench for pong_physics: directed vector table, corner
// sequences and random play against an integer game model.
module tb_pong_physics;

  logic clk50M = 1'b0;
  logic rst    = 1'b1;
  pong_physics_if bus();

  pong_physics dut (
    .clk50M (clk50M),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk50M = ~clk50M;

  int n_chk  = 0;
  int n_fail = 0;

  int m_bx, m_by, m_vx, m_vy, m_p1, m_p2;
  int m_s1, m_s2, m_st, m_cnt;

  typedef struct {
    string name;
    bit    u1, d1, u2, d2;
    int    n;
    int    p1, p2, bx, by, s1, st;
  } vec_t;

  vec_t vecs[14];

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int pmove(int p, bit up, bit dn);
    int d;
    d = (up && !dn) ? -4 : (dn && !up) ? 4 : 0;
    return clampi(p + d, 0, 416);
  endfunction

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_vx = 1; m_vy = 1;
    m_p1 = 208; m_p2 = 208;
    m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0;
  endtask

  task automatic recentre(int vx);
    m_bx = 316; m_by = 236; m_cnt = 0; m_vx = vx;
  endtask

  task automatic model_tick(bit u1, bit d1, bit u2, bit d2);
    int np1, np2, nx, ny;
    np1 = pmove(m_p1, u1, d1);
    np2 = pmove(m_p2, u2, d2);
    if (m_st == 0) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_st = 1; m_cnt = 0;
      end
    end else if (m_st == 1) begin
      nx = m_bx + m_vx;
      ny = m_by + m_vy;
      if (ny == 0)   m_vy = 1;
      if (ny == 472) m_vy = -1;
      if (m_vx < 0 && nx == 24 &&
          ny + 8 > m_p1 && ny < m_p1 + 64) m_vx = 1;
      else if (m_vx > 0 && nx == 608 &&
          ny + 8 > m_p2 && ny < m_p2 + 64) m_vx = -1;
      m_bx = nx; m_by = ny;
      if (nx == 0) begin
        m_s2++;
        recentre(-1);
        m_st = (m_s2 == 9) ? 2 : 0;
      end else if (nx == 632) begin
        m_s1++;
        recentre(1);
        m_st = (m_s1 == 9) ? 2 : 0;
      end
    end
    m_p1 = np1;
    m_p2 = np2;
  endtask

  task automatic check(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_model(string name);
    logic [69:0] got, exp;
    got = {bus.ball_x, bus.ball_y, bus.paddle_one_x,
           bus.paddle_one_y, bus.paddle_two_x,
           bus.paddle_two_y, bus.score_one,
           bus.score_two, bus.state};
    exp = {10'(m_bx), 10'(m_by), 10'd16, 10'(m_p1),
           10'd616, 10'(m_p2), 4'(m_s1), 4'(m_s2),
           2'(m_st)};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // inputs change on negedge; model follows the posedge
  task automatic step(bit t, bit u1, bit d1, bit u2, bit d2);
    bus.tick    = t;
    bus.p1_up   = u1;
    bus.p1_down = d1;
    bus.p2_up   = u2;
    bus.p2_down = d2;
    @(posedge clk50M);
    if (t) model_tick(u1, d1, u2, d2);
    @(negedge clk50M);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk50M);
    rst = 1'b0;
  endtask

  task automatic set_vec(int i, string nm, bit u1, bit d1,
                         bit u2, bit d2, int n, int p1,
                         int p2, int bx, int by, int s1,
                         int st);
    vecs[i].name = nm;
    vecs[i].u1 = u1; vecs[i].d1 = d1;
    vecs[i].u2 = u2; vecs[i].d2 = d2;
    vecs[i].n  = n;
    vecs[i].p1 = p1; vecs[i].p2 = p2;
    vecs[i].bx = bx; vecs[i].by = by;
    vecs[i].s1 = s1; vecs[i].st = st;
  endtask

  bit [3:0] btn;
  int       guard;

  initial begin
    bus.tick = 0;
    bus.p1_up = 0; bus.p1_down = 0;
    bus.p2_up = 0; bus.p2_down = 0;
    model_reset();

    set_vec(0,  "serve59",  0,0,0,0,  59, 208,208,316,236,0,0);
    set_vec(1,  "serve60",  0,0,0,0,  60, 208,208,316,236,0,1);
    set_vec(2,  "serve61",  0,0,0,0,  61, 208,208,317,237,0,1);
    set_vec(3,  "p1_up",    1,0,0,0,  60,   0,208,316,236,0,1);
    set_vec(4,  "p1_both",  1,1,0,0,  10, 208,208,316,236,0,0);
    set_vec(5,  "p2_down",  0,0,0,1,  20, 208,288,316,236,0,0);
    set_vec(6,  "p1_dnclp", 0,1,0,0, 100, 416,208,356,276,0,1);
    set_vec(7,  "bottom",   0,0,0,0, 296, 208,208,552,472,0,1);
    set_vec(8,  "bounce",   0,0,0,0, 297, 208,208,553,471,0,1);
    set_vec(9,  "miss_r",   0,0,0,0, 376, 208,208,316,236,1,0);
    set_vec(10, "reserve",  0,0,0,0, 436, 208,208,316,236,1,1);
    set_vec(11, "dir_kept", 0,0,0,0, 437, 208,208,317,235,1,1);
    set_vec(12, "p2_hit",   0,0,0,1, 352, 208,416,608,416,0,1);
    set_vec(13, "p2_rev",   0,0,0,1, 353, 208,416,607,415,0,1);

    @(negedge clk50M);
    rst = 1'b0;
    check_model("reset_state");

    foreach (vecs[i]) begin
      do_reset();
      repeat (vecs[i].n)
        step(1, vecs[i].u1, vecs[i].d1, vecs[i].u2, vecs[i].d2);
      check({vecs[i].name, ".p1"}, int'(bus.paddle_one_y), vecs[i].p1);
      check({vecs[i].name, ".p2"}, int'(bus.paddle_two_y), vecs[i].p2);
      check({vecs[i].name, ".bx"}, int'(bus.ball_x), vecs[i].bx);
      check({vecs[i].name, ".by"}, int'(bus.ball_y), vecs[i].by);
      check({vecs[i].name, ".s1"}, int'(bus.score_one), vecs[i].s1);
      check({vecs[i].name, ".st"}, int'(bus.state), vecs[i].st);
      check_model({vecs[i].name, ".model"});
    end

    // p1_up held 52 ticks reaches 0, then stays
    do_reset();
    repeat (51) step(1, 1, 0, 0, 0);
    check("clamp51", int'(bus.paddle_one_y), 4);
    step(1, 1, 0, 0, 0);
    check("clamp52", int'(bus.paddle_one_y), 0);

    // idle clocks and button noise without tick
    do_reset();
    repeat (100) step(1, 0, 0, 0, 0);
    repeat (20) begin
      btn = 4'($urandom);
      step(0, btn[0], btn[1], btn[2], btn[3]);
    end
    check_model("idle");
    check("idle_bx", int'(bus.ball_x), 356);

    // asynchronous reset mid-PLAY, away from any edge
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    check("async_rst_st", int'(bus.state), 0);
    @(negedge clk50M);
    rst = 1'b0;
    step(1, 0, 0, 0, 0);
    check_model("post_rst_tick");

    // nine right-wall misses end the game
    do_reset();
    guard = 0;
    while (bus.state != 2'd2 && guard < 5000) begin
      step(1, 0, 0, 0, 0);
      check_model("to_over");
      guard++;
    end
    check("over_reached", int'(bus.state), 2);
    check("over_ticks", guard, 9 * 376);
    check("over_s1", int'(bus.score_one), 9);
    repeat (1000) begin
      btn = 4'($urandom);
      step(1, btn[0], btn[1], btn[2], btn[3]);
    end
    check_model("over_frozen");
    check("over_bx", int'(bus.ball_x), 316);
    check("over_by", int'(bus.ball_y), 236);
    check("over_s1_hold", int'(bus.score_one), 9);
    #2 rst = 1'b1;
    #1;
    check("over_rst_st", int'(bus.state), 0);
    check("over_rst_s1", int'(bus.score_one), 0);
    @(negedge clk50M);
    rst = 1'b0;
    model_reset();

    // random play against the model
    btn = 4'd0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 15) == 0) btn = 4'($urandom);
      step($urandom_range(0, 3) != 0, btn[0], btn[1],
           btn[2], btn[3]);
      check_model("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
